// File: rtl/cordic_phase_front_if.sv
// rtl/cordic_phase_front_if.sv - tick/phase inputs and x/y/z/valid bundle for cordic_phase_front
interface cordic_phase_front_if;
    logic               tick;
    logic        [31:0] phase_inc;
    logic               phase_load;
    logic        [31:0] phase_init;
    logic signed [15:0] x_out;
    logic signed [15:0] y_out;
    logic signed [15:0] z_out;
    logic               valid_out;
    logic        [31:0] phase_out;

    modport master (
        output tick, phase_inc, phase_load, phase_init,
        input  x_out, y_out, z_out, valid_out, phase_out
    );

    modport slave (
        input  tick, phase_inc, phase_load, phase_init,
        output x_out, y_out, z_out, valid_out, phase_out
    );
endinterface

// File: rtl/cordic_phase_front.sv
// rtl/cordic_phase_front.sv - phase accumulator, pi fold and radian scaling ahead of the first CORDIC stage
// Optional sample dither enabled by defining CORDIC_PHASE_DITHER_EN.
module cordic_phase_front #(
    parameter int X_INIT      = 19898,
    parameter int ANGLE_SCALE = 51472
) (
    input  logic clock,
    input  logic reset,
    cordic_phase_front_if.slave bus
);
    localparam logic signed [15:0] X_W     = 16'(X_INIT);
    localparam logic signed [32:0] SCALE_W = 33'(ANGLE_SCALE);

    logic        [31:0] acc_q, acc_d;
    logic        [31:0] acc_base;
    logic        [31:0] sample;
    logic signed [15:0] p;
    logic               fold;
    logic signed [15:0] p_a_q, p_a_d;
    logic               fold_a_q, fold_a_d;
    logic               valid_a_q, valid_a_d;
    logic signed [32:0] prod;
    logic signed [15:0] x_q, x_d;
    logic signed [15:0] z_q, z_d;
    logic               valid_q, valid_d;

`ifdef CORDIC_PHASE_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;
`endif

    always_comb begin
        acc_base = bus.phase_load ? bus.phase_init : acc_q;
        acc_d    = bus.tick ? acc_base + bus.phase_inc : acc_base;

`ifdef CORDIC_PHASE_DITHER_EN
        // Dither only perturbs the emitted sample; the accumulator stays exact.
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = bus.tick ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
        sample  = acc_base + {16'h0000, lfsr_q};
`else
        sample  = acc_base;
`endif

        p    = 16'(sample >> 16);
        // Angles outside [-pi/2, pi/2) have differing top two bits; rotate them by pi.
        fold = p[15] ^ p[14];

        p_a_d     = p_a_q;
        fold_a_d  = fold_a_q;
        valid_a_d = bus.tick;
        if (bus.tick) begin
            p_a_d    = fold ? (p ^ 16'sh8000) : p;
            fold_a_d = fold;
        end

        prod    = 33'(p_a_q) * SCALE_W;
        x_d     = x_q;
        z_d     = z_q;
        valid_d = valid_a_q;
        if (valid_a_q) begin
            z_d = 16'(prod >>> 16);
            x_d = fold_a_q ? -X_W : X_W;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            p_a_q     <= '0;
            fold_a_q  <= 1'b0;
            valid_a_q <= 1'b0;
            x_q       <= '0;
            z_q       <= '0;
            valid_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            p_a_q     <= p_a_d;
            fold_a_q  <= fold_a_d;
            valid_a_q <= valid_a_d;
            x_q       <= x_d;
            z_q       <= z_d;
            valid_q   <= valid_d;
        end
    end

`ifdef CORDIC_PHASE_DITHER_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign bus.x_out     = x_q;
    assign bus.y_out     = 16'sd0;
    assign bus.z_out     = z_q;
    assign bus.valid_out = valid_q;
    assign bus.phase_out = acc_q;
endmodule

// File: tb/tb_cordic_phase_front.sv
// tb/tb_cordic_phase_front.sv - randomized self-checking bench for cordic_phase_front
module tb_cordic_phase_front;
    logic clock;
    logic reset;
    cordic_phase_front_if bus ();

    cordic_phase_front dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference: accumulator plus a two-deep queue of finished samples.
    logic        [31:0] m_acc;
    logic               s1_v;
    logic signed [15:0] s1_x, s1_z;
    logic               m_valid;
    logic signed [15:0] m_x, m_z;

    function automatic void model_sample(input logic [31:0] s,
                                         output logic signed [15:0] x,
                                         output logic signed [15:0] z);
        int     p;
        bit     neg;
        longint prod;
        p   = int'($signed(s[31:16]));
        neg = 1'b0;
        if (p >= 16384) begin
            p   = p - 32768;
            neg = 1'b1;
        end else if (p < -16384) begin
            p   = p + 32768;
            neg = 1'b1;
        end
        prod = longint'(p) * 64'sd51472;
        z    = 16'(prod >>> 16);
        x    = neg ? -16'sd19898 : 16'sd19898;
    endfunction

    task automatic model_reset();
        m_acc   = '0;
        s1_v    = 1'b0;
        s1_x    = '0;
        s1_z    = '0;
        m_valid = 1'b0;
        m_x     = '0;
        m_z     = '0;
    endtask

    task automatic cycle(input logic t, input logic ld, input logic [31:0] init, input logic [31:0] inc);
        logic        [31:0] s;
        logic signed [15:0] nx, nz;
        bus.tick       = t;
        bus.phase_load = ld;
        bus.phase_init = init;
        bus.phase_inc  = inc;
        @(posedge clock);
        m_valid = s1_v;
        if (s1_v) begin
            m_x = s1_x;
            m_z = s1_z;
        end
        s = ld ? init : m_acc;
        s1_v = t;
        if (t) begin
            model_sample(s, nx, nz);
            s1_x = nx;
            s1_z = nz;
        end
        m_acc = t ? s + inc : s;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.tick       = 1'b0;
        bus.phase_load = 1'b0;
        bus.phase_init = '0;
        bus.phase_inc  = '0;
        model_reset();
        repeat (2) @(negedge clock);
        n_cmp += 4;
        if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL reset valid_out: got %0b want 0", bus.valid_out); end
        if (bus.x_out !== 16'sd0) begin n_err++; $display("FAIL reset x_out: got %0d want 0", bus.x_out); end
        if (bus.z_out !== 16'sd0 || bus.y_out !== 16'sd0) begin n_err++; $display("FAIL reset z/y: got %0d/%0d want 0/0", bus.z_out, bus.y_out); end
        if (bus.phase_out !== 32'h0) begin n_err++; $display("FAIL reset phase_out: got %h want 0", bus.phase_out); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_zero();
        logic [31:0] inc;
        inc = $urandom;
        cycle(1'b1, 1'b1, 32'h0, inc);
        n_cmp += 2;
        if (bus.phase_out !== inc) begin n_err++; $display("FAIL single phase_out: got %h want %h", bus.phase_out, inc); end
        if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL single early valid: got %0b want 0", bus.valid_out); end
        cycle(1'b0, 1'b0, 32'h0, inc);
        n_cmp += 4;
        if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL single valid: got %0b want 1", bus.valid_out); end
        if (bus.x_out !== 16'sd19898) begin n_err++; $display("FAIL single x_out: got %0d want 19898", bus.x_out); end
        if (bus.y_out !== 16'sd0) begin n_err++; $display("FAIL single y_out: got %0d want 0", bus.y_out); end
        if (bus.z_out !== 16'sd0) begin n_err++; $display("FAIL single z_out: got %0d want 0", bus.z_out); end
        cycle(1'b0, 1'b0, 32'h0, inc);
        n_cmp++;
        if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL single valid width: got %0b want 0", bus.valid_out); end
    endtask

    task automatic test_boundaries();
        logic [31:0] starts [3] = '{32'h40000000, 32'h80000000, 32'hC0000000};
        int          want_x [3] = '{-19898, -19898, 19898};
        int          want_z [3] = '{-12868, 0, -12868};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, starts[i], 32'h1);
            cycle(1'b0, 1'b0, 32'h0, 32'h1);
            n_cmp += 3;
            if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL boundary %h valid: got %0b want 1", starts[i], bus.valid_out); end
            if (bus.x_out !== 16'(want_x[i])) begin n_err++; $display("FAIL boundary %h x_out: got %0d want %0d", starts[i], bus.x_out, want_x[i]); end
            if (bus.z_out !== 16'(want_z[i])) begin n_err++; $display("FAIL boundary %h z_out: got %0d want %0d", starts[i], bus.z_out, want_z[i]); end
        end
        cycle(1'b1, 1'b1, 32'hFFFFFFFF, 32'h1);
        n_cmp++;
        if (bus.phase_out !== 32'h0) begin n_err++; $display("FAIL wrap phase_out: got %h want 0", bus.phase_out); end
        cycle(1'b1, 1'b0, 32'h0, 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 32'h1);
        n_cmp += 2;
        if (bus.phase_out !== 32'h1) begin n_err++; $display("FAIL wrap phase_out next: got %h want 1", bus.phase_out); end
        if (bus.z_out !== 16'sd0 || bus.x_out !== 16'sd19898) begin n_err++; $display("FAIL wrap sample: got x=%0d z=%0d want x=19898 z=0", bus.x_out, bus.z_out); end
    endtask

    task automatic test_sweep();
        int want_z [9] = '{0, 6434, -12868, -6434, 0, 6434, -12868, -6434, 0};
        bit want_n [9] = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
        int k = 0;
        for (int i = 0; i < 11; i++) begin
            cycle(i < 9, i == 0, 32'h0, 32'h20000000);
            n_cmp += 4;
            if (bus.valid_out !== (i >= 1 && i < 10)) begin n_err++; $display("FAIL sweep valid cycle %0d: got %0b want %0b", i, bus.valid_out, (i >= 1 && i < 10)); end
            if (bus.valid_out !== m_valid || bus.x_out !== m_x || bus.z_out !== m_z) begin
                n_err++; $display("FAIL sweep model cycle %0d: got v=%0b x=%0d z=%0d want v=%0b x=%0d z=%0d", i, bus.valid_out, bus.x_out, bus.z_out, m_valid, m_x, m_z);
            end
            if (bus.phase_out !== m_acc) begin n_err++; $display("FAIL sweep phase_out cycle %0d: got %h want %h", i, bus.phase_out, m_acc); end
            if (i >= 1 && i < 10) begin
                if (bus.z_out !== 16'(want_z[k]) || bus.x_out !== (want_n[k] ? -16'sd19898 : 16'sd19898)) begin
                    n_err++; $display("FAIL sweep table %0d: got x=%0d z=%0d want neg=%0b z=%0d", k, bus.x_out, bus.z_out, want_n[k], want_z[k]);
                end
                k++;
            end else begin
                n_cmp--;
            end
        end
    endtask

    task automatic test_gapped();
        logic [31:0] prev;
        cycle(1'b0, 1'b1, 32'h0, 32'h10000000);
        prev = 32'h0;
        for (int i = 0; i < 15; i++) begin
            cycle(i % 3 == 0, 1'b0, 32'h0, 32'h10000000);
            if (i % 3 == 0) prev = prev + 32'h10000000;
            n_cmp += 4;
            if (bus.valid_out !== (i % 3 == 1)) begin n_err++; $display("FAIL gapped valid cycle %0d: got %0b want %0b", i, bus.valid_out, (i % 3 == 1)); end
            if (bus.phase_out !== prev) begin n_err++; $display("FAIL gapped phase_out cycle %0d: got %h want %h", i, bus.phase_out, prev); end
            if (bus.x_out !== m_x) begin n_err++; $display("FAIL gapped x_out cycle %0d: got %0d want %0d", i, bus.x_out, m_x); end
            if (bus.z_out !== m_z) begin n_err++; $display("FAIL gapped z_out cycle %0d: got %0d want %0d", i, bus.z_out, m_z); end
        end
    endtask

    task automatic test_load_no_tick();
        cycle(1'b0, 1'b1, 32'hC0000000, 32'h01234567);
        cycle(1'b0, 1'b0, 32'h0, 32'h01234567);
        n_cmp += 2;
        if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL load_no_tick valid: got %0b want 0", bus.valid_out); end
        if (bus.phase_out !== 32'hC0000000) begin n_err++; $display("FAIL load_no_tick phase_out: got %h want c0000000", bus.phase_out); end
        cycle(1'b1, 1'b0, 32'h0, 32'h01234567);
        cycle(1'b0, 1'b0, 32'h0, 32'h01234567);
        n_cmp += 3;
        if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL load_no_tick sample valid: got %0b want 1", bus.valid_out); end
        if (bus.z_out !== -16'sd12868) begin n_err++; $display("FAIL load_no_tick z_out: got %0d want -12868", bus.z_out); end
        if (bus.x_out !== 16'sd19898) begin n_err++; $display("FAIL load_no_tick x_out: got %0d want 19898", bus.x_out); end
    endtask

    task automatic test_random();
        logic t, ld;
        for (int i = 0; i < 400; i++) begin
            t  = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 7) == 0);
            cycle(t, ld, $urandom, $urandom);
            n_cmp += 4;
            if (bus.valid_out !== m_valid) begin n_err++; $display("FAIL random valid cycle %0d: got %0b want %0b", i, bus.valid_out, m_valid); end
            if (bus.x_out !== m_x) begin n_err++; $display("FAIL random x_out cycle %0d: got %0d want %0d", i, bus.x_out, m_x); end
            if (bus.z_out !== m_z || bus.y_out !== 16'sd0) begin n_err++; $display("FAIL random z/y cycle %0d: got %0d/%0d want %0d/0", i, bus.z_out, bus.y_out, m_z); end
            if (bus.phase_out !== m_acc) begin n_err++; $display("FAIL random phase_out cycle %0d: got %h want %h", i, bus.phase_out, m_acc); end
        end
    endtask

    task automatic test_reset_midstream();
        cycle(1'b1, 1'b1, 32'h20000000, 32'h20000000);
        cycle(1'b1, 1'b0, 32'h0, 32'h20000000);
        reset = 1'b1;
        #1;
        model_reset();
        n_cmp += 3;
        if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL midreset valid: got %0b want 0", bus.valid_out); end
        if (bus.x_out !== 16'sd0 || bus.z_out !== 16'sd0) begin n_err++; $display("FAIL midreset x/z: got %0d/%0d want 0/0", bus.x_out, bus.z_out); end
        if (bus.phase_out !== 32'h0) begin n_err++; $display("FAIL midreset phase_out: got %h want 0", bus.phase_out); end
        bus.tick = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 32'h20000000);
            n_cmp++;
            if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL midreset stale valid cycle %0d: got %0b want 0", i, bus.valid_out); end
        end
        cycle(1'b1, 1'b0, 32'h0, 32'h20000000);
        n_cmp++;
        if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL midreset early valid: got %0b want 0", bus.valid_out); end
        cycle(1'b0, 1'b0, 32'h0, 32'h20000000);
        n_cmp += 2;
        if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL midreset latency valid: got %0b want 1", bus.valid_out); end
        if (bus.z_out !== 16'sd0 || bus.x_out !== 16'sd19898) begin n_err++; $display("FAIL midreset sample: got x=%0d z=%0d want 19898/0", bus.x_out, bus.z_out); end
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_boundaries();
        test_sweep();
        test_gapped();
        test_load_no_tick();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/cordic_phase_front.md
Name: cordic_phase_front

Overview:
- Front end that sits directly upstream of the first CORDIC rotation stage.
- Keeps a 32-bit phase accumulator that advances on a sample tick.
- Folds each phase sample into [-pi/2, pi/2) by pre-rotating by pi, then scales it to radians.
- Emits the x/y/z/valid bundle that the rotation-stage chain consumes: x = ±X_INIT, y = 0, z = folded angle.

Parameters:
- X_INIT, 19898, initial x magnitude in Q1.15 (CORDIC gain compensation 0.60725 × 32768).
- ANGLE_SCALE, 51472, unsigned 17-bit constant round(2·pi·8192); converts signed half-turn fraction to Q3.13 radians.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  sample strobe; each high cycle emits one sample
- phase_inc  in  32  unsigned phase increment per tick (2^32 = one turn)
- phase_load  in  1  load accumulator from phase_init
- phase_init  in  32  load value
- x_out  out  16  signed Q1.15 initial x, to first rotation stage
- y_out  out  16  signed initial y, always 0
- z_out  out  16  signed Q3.13 radians, range [-12868, 12867]
- valid_out  out  1  sample valid
- phase_out  out  32  current accumulator value

Behaviour:
- Reset (async, high): accumulator, both pipeline registers, x_out, y_out, z_out, valid_out and phase_out all clear to 0. Any in-flight samples are discarded.
- Accumulator update, per cycle:
  - phase_load=1: sample phase S = phase_init. Next accumulator = phase_init + phase_inc if tick=1, else phase_init.
  - phase_load=0: S = accumulator. Next accumulator = accumulator + phase_inc if tick=1, else unchanged.
  - The add wraps modulo 2^32.
  - A load without tick emits no sample.
- Stage A (register, launched when tick=1):
  - p = S[31:16] as signed 16-bit.
  - If p[15:14] is 00 or 11: fold_a = 0, p_a = p.
  - Otherwise: fold_a = 1, p_a = p + 16'h8000 (wrapping).
  - valid_a = tick.
- Stage B (register):
  - z_out = (p_a × ANGLE_SCALE) >>> 16, computed as a 33-bit signed product with arithmetic (floor) shift, truncated to 16 bits.
  - x_out = fold_a ? -X_INIT : X_INIT.
  - y_out = 0; valid_out = valid_a.
- Latency: a tick in cycle n produces valid_out in cycle n+2.
- Throughput: one sample per cycle; back-to-back ticks are supported.
- Data registers load only when their stage's valid input is 1. When not valid, x/z outputs hold their last values and valid_out = 0.
- No backpressure: downstream stages have no ready signal and always accept.
- Boundary conditions:
  - p = 0x4000 (+pi/2) folds to -16384.
  - p = 0x8000 (-pi) folds to 0 with x negated.
  - p = 0xC000 (-pi/2) does not fold.
  - Accumulator wrap from 0xFFFFFFFF is seamless.
- phase_out is the registered accumulator. It updates one cycle after tick or load.

Optional Feature:
- Macro: CORDIC_PHASE_DITHER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per tick.
  - Before truncation, S is replaced by S + {16'h0, lfsr}, wrapping.
  - Dither affects the emitted sample only, never the accumulator.
- When undefined: plain truncation of S[31:16]; no LFSR logic is instantiated.
- Test-plan values below assume the macro is undefined.

Test Plan:
- Reset check: assert reset mid-stream with two samples in flight -> all outputs 0 immediately; no valid_out after release until a new tick, then exactly 2 cycles later.
- Single sample at zero: phase_load=1, phase_init=0, tick=1 for one cycle -> valid_out one cycle at n+2, x_out=19898, y_out=0, z_out=0; phase_out=phase_inc.
- Fold at +pi/2: phase_load=1, phase_init=32'h40000000, tick -> x_out=-19898, z_out=-12868.
- Continuous sweep: load 0, phase_inc=32'h20000000, tick held 9 cycles -> (x_out sign, z_out) sequence:
  - (+,0), (+,6434), (-,-12868), (-,-6434), (-,0)
  - (-,6434), (+,-12868), (+,-6434), (+,0) after wrap
  - valid_out high for 9 consecutive cycles.
- Gapped ticks: tick every third cycle with phase_inc=32'h10000000 -> valid_out pulses every third cycle; x_out/z_out hold between pulses; phase_out steps 0x10000000 per tick.
- Load without tick: phase_load=1, phase_init=32'hC0000000, tick=0 -> no valid_out; phase_out=32'hC0000000. Next tick -> z_out=-12868, x_out=+19898.
